// File: rtl/wb_boot_pkg.sv
// Shared definitions for the boot copier: FSM state encoding, byte-select constant, index sizing.
package wb_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    // A single-word image still needs a 1-bit index register.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_boot_timer.sv
// Per-access watchdog: saturating cycle counter with an expiry compare against TIMEOUT.
// Registered count; o_expired is a decode of the count, so the abort lands one cycle after the limit.
module wb_boot_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CW{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/wb_boot_copier.sv
// Wishbone master copying LEN_WORDS words from the ROM window to the RAM window, then releasing the core.
// Outputs registered; each access holds its strobe until ack/err, or the watchdog aborts it.
module wb_boot_copier
    import wb_boot_pkg::*;
#(
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter logic [AW-1:0] SRC_BASE  = '0,
    parameter logic [AW-1:0] DST_BASE  = AW'(32'h1000_0000),
    parameter int            LEN_WORDS = 2048,
    parameter int            TIMEOUT   = 255,
    parameter int            AUTOSTART = 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          start_i,
    output logic [AW-1:0] wbm_adr_o,
    output logic [DW-1:0] wbm_dat_o,
    input  logic [DW-1:0] wbm_dat_i,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          cpu_rst_o
);
    localparam int            IW       = idx_bits(LEN_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(LEN_WORDS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic          r_boot;
    logic [DW-1:0] r_dat;

    logic          r_cyc;
    logic          r_stb;
    logic          r_we;
    logic [3:0]    r_sel;
    logic [AW-1:0] r_adr;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_cpu_rst;

    logic          w_active;
    logic          w_nxt_active;
    logic          w_expired;
    logic          w_fail;
    logic          w_go;
    logic          w_tmr_clr;
    logic [AW-1:0] w_off;

    assign w_active     = (r_state == ST_RD) || (r_state == ST_WR);
    assign w_nxt_active = (w_state_nxt == ST_RD) || (w_state_nxt == ST_WR);
    // Error and timeout both win over a coincident ack.
    assign w_fail       = w_active && (wbm_err_i || w_expired);
    assign w_tmr_clr    = !w_active || wbm_ack_i || wbm_err_i;
    assign w_off        = AW'(w_idx_nxt) << 2;

    wb_boot_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (wb_clk_i),
        .i_rst_n   (wb_rst_n_i),
        .i_clr     (w_tmr_clr),
        .i_inc     (w_active),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_go        = 1'b0;
        case (r_state)
            ST_IDLE: w_go = start_i || ((AUTOSTART != 0) && r_boot);
            ST_RD: begin
                if (w_fail) begin
                    w_state_nxt = ST_ERR;
                end else if (wbm_ack_i) begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                if (w_fail) begin
                    w_state_nxt = ST_ERR;
                end else if (wbm_ack_i) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RD;
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERR: w_go = start_i;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_go) begin
            w_state_nxt = ST_RD;
            w_idx_nxt   = '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_boot  <= 1'b1;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_boot  <= 1'b0;
            if ((r_state == ST_RD) && wbm_ack_i && !w_fail) begin
                r_dat <= wbm_dat_i;
            end
        end
    end

    // Bus and status outputs are decoded from the next state so they change on the entry edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 4'h0;
            r_adr     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b1;
        end else begin
            r_cyc     <= w_nxt_active;
            r_stb     <= w_nxt_active;
            r_we      <= (w_state_nxt == ST_WR);
            r_sel     <= w_nxt_active ? WB_SEL_ALL : 4'h0;
            r_adr     <= (w_state_nxt == ST_RD) ? SRC_BASE + w_off :
                         (w_state_nxt == ST_WR) ? DST_BASE + w_off : '0;
            r_busy    <= w_nxt_active;
            r_done    <= (w_state_nxt == ST_DONE);
            r_err     <= (w_state_nxt == ST_ERR);
            r_cpu_rst <= (w_state_nxt != ST_DONE);
        end
    end

    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;
    assign wbm_we_o  = r_we;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign cpu_rst_o = r_cpu_rst;

endmodule

// File: tb/tb_wb_boot_copier.sv
// Bench for wb_boot_copier: negedge-driven ROM/RAM slave model with an expected-access queue.
module tb_wb_boot_copier;
    localparam int          LEN = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] SRC = 32'h0000_0000;
    localparam logic [31:0] DST = 32'h1000_0000;

    logic        wb_clk_i   = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        start_i    = 1'b0;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        cpu_rst_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_boot_copier #(
        .AW(32), .DW(32), .SRC_BASE(SRC), .DST_BASE(DST),
        .LEN_WORDS(LEN), .TIMEOUT(TO), .AUTOSTART(1)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .start_i(start_i),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cpu_rst_o(cpu_rst_o)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
    } acc_t;

    logic [31:0] rom [LEN];
    logic [31:0] ram [LEN];
    acc_t        exp_q [$];

    int n_cmp, n_bad;
    int cyc_n, first_stb, done_at, rel_at;
    int wcnt, cur_lat, lat_lo, lat_hi, acc_no, err_at;
    bit noack, done_prev, rst_prev;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: a full copy is RD(SRC+4i) then WR(DST+4i, rom[i]) for i = 0..LEN-1.
    task automatic plan_copy();
        acc_t a;
        exp_q.delete();
        for (int i = 0; i < LEN; i++) begin
            a.adr = SRC + 32'(4 * i); a.we = 1'b0; a.dat = '0;     a.sel = 4'hF;
            exp_q.push_back(a);
            a.adr = DST + 32'(4 * i); a.we = 1'b1; a.dat = rom[i]; a.sel = 4'hF;
            exp_q.push_back(a);
        end
        first_stb = -1; done_at = -1; rel_at = -1;
        acc_no = 0; wcnt = 0;
        cur_lat = int'($urandom_range(lat_hi, lat_lo));
    endtask

    task automatic fresh_image(input bit fixed);
        for (int i = 0; i < LEN; i++) begin
            rom[i] = fixed ? 32'hA0 + 32'(i) : $urandom;
            ram[i] = 32'hDEAD_BEEF;
        end
    endtask

    // One bus cycle of the slave: check the strobed access, respond after cur_lat strobe cycles.
    task automatic tick();
        acc_t obs;
        int   k;
        @(negedge wb_clk_i);
        cyc_n++;
        if (wbm_ack_i || wbm_err_i) begin
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wcnt = 0;
        end
        if (wbm_cyc_o && wbm_stb_o) begin
            if (first_stb < 0) first_stb = cyc_n;
            obs.adr = wbm_adr_o; obs.we = wbm_we_o;
            obs.dat = wbm_we_o ? wbm_dat_o : '0; obs.sel = wbm_sel_o;
            if (exp_q.size() == 0) begin
                check("no_access", {wbm_cyc_o, wbm_stb_o}, 2'b00);
            end else begin
                check("bus_access", obs, exp_q[0]);
                wcnt++;
                if (!noack && wcnt >= cur_lat) begin
                    if (acc_no == err_at) begin
                        wbm_err_i = 1'b1;
                        exp_q.delete();
                    end else begin
                        wbm_ack_i = 1'b1;
                        k = int'((obs.adr - (obs.we ? DST : SRC)) >> 2);
                        if (k >= 0 && k < LEN) begin
                            if (obs.we) ram[k] = wbm_dat_o;
                            else        wbm_dat_i = rom[k];
                        end
                        void'(exp_q.pop_front());
                    end
                    acc_no++;
                    cur_lat = int'($urandom_range(lat_hi, lat_lo));
                end
            end
        end
        if (done_o && !done_prev) done_at = cyc_n;
        if (!cpu_rst_o && rst_prev) rel_at = cyc_n;
        done_prev = done_o;
        rst_prev  = cpu_rst_o;
    endtask

    task automatic wait_idle(input string tag);
        int b;
        b = 0;
        while (busy_o && b < 400) begin
            tick();
            b++;
        end
        check({tag, "_completes"}, {busy_o, wbm_cyc_o}, 2'b00);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < LEN; i++) check(tag, ram[i], rom[i]);
    endtask

    initial begin
        int b, n;
        n_cmp = 0; n_bad = 0; cyc_n = 0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
        noack = 1'b0; err_at = -1; lat_lo = 2; lat_hi = 2;
        done_prev = 1'b0; rst_prev = 1'b1;

        // Reset values, then autostart with a registered-ack slave and image A0..A3.
        fresh_image(1'b1);
        plan_copy();
        repeat (3) @(negedge wb_clk_i);
        check("reset_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, '0);
        check("reset_status", {busy_o, done_o, err_o, cpu_rst_o}, 4'b0001);
        wb_rst_n_i = 1'b1;
        tick();
        check("auto_first_adr", {wbm_stb_o, wbm_adr_o}, {1'b1, SRC});
        wait_idle("t1");
        check_ram("t1_ram");
        check("t1_latency", done_at - first_stb, 4 * LEN);
        check("t1_cpu_rst_same_cycle", rel_at, done_at);
        check("t1_status", {busy_o, done_o, err_o, cpu_rst_o}, 4'b0100);

        // Re-copy from DONE with variable ack latency; a start while busy must be ignored.
        fresh_image(1'b0);
        lat_lo = 2; lat_hi = 4;
        plan_copy();
        pulse_start();
        check("t2_recopy_status", {busy_o, done_o, err_o, cpu_rst_o}, 4'b1001);
        repeat (5) tick();
        pulse_start();
        wait_idle("t2");
        check_ram("t2_ram");
        check("t2_status", {busy_o, done_o, err_o, cpu_rst_o}, 4'b0100);

        // Error on the write of idx 1 (access #3): bus drops, core stays in reset, then retry.
        fresh_image(1'b0);
        err_at = 3;
        plan_copy();
        pulse_start();
        b = 0;
        while (!wbm_err_i && b < 100) begin
            tick();
            b++;
        end
        check("t3_err_injected", wbm_err_i, 1'b1);
        tick();
        check("t3_bus_released", {wbm_cyc_o, wbm_stb_o, wbm_sel_o}, '0);
        check("t3_status", {busy_o, done_o, err_o, cpu_rst_o}, 4'b0011);
        repeat (3) tick();
        check("t3_ram0_written", ram[0], rom[0]);
        check("t3_ram1_untouched", ram[1], 32'hDEAD_BEEF);
        err_at = -1;
        plan_copy();
        pulse_start();
        check("t3_retry_adr", {wbm_stb_o, wbm_we_o, wbm_adr_o}, {2'b10, SRC});
        check("t3_retry_status", {busy_o, done_o, err_o, cpu_rst_o}, 4'b1001);
        wait_idle("t3");
        check_ram("t3_ram");
        check("t3_done", {done_o, err_o}, 2'b10);

        // No ack: strobe held while the count runs 0..TO, abort on the next edge.
        noack = 1'b1;
        plan_copy();
        pulse_start();
        n = wbm_stb_o ? 1 : 0;
        b = 0;
        while (wbm_stb_o && b < 50) begin
            tick();
            if (wbm_stb_o) n++;
            b++;
        end
        check("t4_stb_cycles", n, TO + 1);
        check("t4_status", {busy_o, done_o, err_o, cpu_rst_o, wbm_cyc_o, wbm_stb_o}, 6'b001100);
        noack = 1'b0;

        // Asynchronous reset during the write of idx 1, then autostart from idx 0.
        fresh_image(1'b0);
        plan_copy();
        pulse_start();
        b = 0;
        while (!(wbm_stb_o && wbm_we_o && acc_no >= 3) && b < 100) begin
            tick();
            b++;
        end
        check("t5_in_wr1", {wbm_stb_o, wbm_we_o, wbm_adr_o}, {2'b11, DST + 32'd4});
        #2 wb_rst_n_i = 1'b0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        #1;
        check("t5_async_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, '0);
        check("t5_async_status", {busy_o, done_o, err_o, cpu_rst_o}, 4'b0001);
        repeat (2) @(negedge wb_clk_i);
        fresh_image(1'b0);
        plan_copy();
        done_prev = 1'b0; rst_prev = 1'b1;
        wb_rst_n_i = 1'b1;
        tick();
        check("t5_restart_adr", {wbm_stb_o, wbm_we_o, wbm_adr_o}, {2'b10, SRC});
        wait_idle("t5");
        check_ram("t5_ram");
        check("t5_status", {busy_o, done_o, err_o, cpu_rst_o}, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
